// File: rtl/fp_pkg.sv
// Shared single-precision types, constants and inter-stage payloads for the FPU datapath.
package fp_pkg;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] man;
   } fp32_t;

   localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
   localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
   localparam int          FP_BIAS    = 127;

   // S1 -> S2: primary/secondary significands as {hidden, man[22:0], guard, round, sticky}
   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [26:0] ma;
      logic [26:0] mb;
      logic        sub;
      logic        zsign;
      logic        spec;
      logic [31:0] spec_val;
   } s12_t;

   // S2 -> S3: raw magnitude sum (bit 27 is the carry) and its leading-zero count
   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [27:0] sum;
      logic [4:0]  lzc;
      logic        zsign;
      logic        spec;
      logic [31:0] spec_val;
   } s23_t;

endpackage

// File: rtl/fsub_pipe_if.sv
// Operand/result handshake bundle for the pipelined subtractor.
interface fsub_pipe_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] x1;
   logic [31:0] x2;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] y;
   logic        ovf;

   modport master (
      output in_valid, x1, x2, out_ready,
      input  in_ready, out_valid, y, ovf
   );

   modport slave (
      input  in_valid, x1, x2, out_ready,
      output in_ready, out_valid, y, ovf
   );
endinterface

// File: rtl/lzc27.sv
// Combinational leading-zero counter over 27 bits; returns 27 for an all-zero input.
module lzc27 (
   input  logic [26:0] d,
   output logic [4:0]  cnt
);
   // the highest set bit is the last one to write the count
   always_comb begin
      cnt = 5'd27;
      for (int i = 0; i < 27; i++) begin
         if (d[i]) cnt = 5'(26 - i);
      end
   end
endmodule

// File: rtl/fsub_pipe.sv
// Three-stage IEEE single-precision subtractor y = x1 - x2, RNE rounding, subnormals flushed.
module fsub_pipe
   import fp_pkg::*;
(
   input logic        clk,
   input logic        rst,
   fsub_pipe_if.slave bus
);
   logic        v1, v2, v3;
   logic        ld1, ld2, ld3;
   s12_t        s12_d, s12_q;
   s23_t        s23_d, s23_q;
   logic [31:0] y_d, y_q;
   logic        ovf_d, ovf_q;

   // a stage loads when it is empty or its successor is taking its contents
   assign ld3 = !v3 || bus.out_ready;
   assign ld2 = !v2 || ld3;
   assign ld1 = !v1 || ld2;

   assign bus.in_ready  = ld1;
   assign bus.out_valid = v3;
   assign bus.y         = y_q;
   assign bus.ovf       = ovf_q;

   // ---------------- S1: unpack, specials, swap, align ----------------
   fp32_t       a, b;
   logic        sb;
   logic        a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
   logic [30:0] ka, kb;
   logic        swap;
   logic [23:0] ma24, mb24, mp, ms;
   logic [7:0]  ep, es, diff;
   logic [4:0]  sh;
   logic [57:0] wide;

   assign a      = fp32_t'(bus.x1);
   assign b      = fp32_t'(bus.x2);
   assign sb     = ~b.sign;
   assign a_zero = (a.exp == 8'd0);
   assign b_zero = (b.exp == 8'd0);
   assign a_nan  = (a.exp == FP_EXP_MAX) && (a.man != 23'd0);
   assign b_nan  = (b.exp == FP_EXP_MAX) && (b.man != 23'd0);
   assign a_inf  = (a.exp == FP_EXP_MAX) && (a.man == 23'd0);
   assign b_inf  = (b.exp == FP_EXP_MAX) && (b.man == 23'd0);
   assign ka     = a_zero ? 31'd0 : {a.exp, a.man};
   assign kb     = b_zero ? 31'd0 : {b.exp, b.man};
   assign swap   = (kb > ka);
   assign ma24   = a_zero ? 24'd0 : {1'b1, a.man};
   assign mb24   = b_zero ? 24'd0 : {1'b1, b.man};
   assign mp     = swap ? mb24 : ma24;
   assign ms     = swap ? ma24 : mb24;
   assign ep     = swap ? b.exp : a.exp;
   assign es     = swap ? a.exp : b.exp;
   assign diff   = ep - es;
   assign sh     = (diff > 8'd31) ? 5'd31 : diff[4:0];
   // the low 31 bits catch everything shifted below the sticky position
   assign wide   = {ms, 3'b000, 31'd0} >> sh;

   // build the S1 payload, specials resolved up front
   always_comb begin
      s12_d       = '0;
      s12_d.sign  = swap ? sb : a.sign;
      s12_d.exp   = ep;
      s12_d.ma    = {mp, 3'b000};
      s12_d.mb    = wide[57:31] | {26'd0, |wide[30:0]};
      s12_d.sub   = a.sign ^ sb;
      s12_d.zsign = a.sign & sb;
      s12_d.spec  = a_nan | b_nan | a_inf | b_inf;
      if (a_nan || b_nan || (a_inf && b_inf && (a.sign == b.sign)))
         s12_d.spec_val = FP_QNAN;
      else if (a_inf)
         s12_d.spec_val = {a.sign, FP_EXP_MAX, 23'd0};
      else
         s12_d.spec_val = {sb, FP_EXP_MAX, 23'd0};
   end

   // ---------------- S2: magnitude add/sub, leading-zero count ----------------
   logic [27:0] sum;
   logic [4:0]  lzc;

   // primary magnitude is never smaller than the aligned secondary, so no negative sums
   assign sum = s12_q.sub ? ({1'b0, s12_q.ma} - {1'b0, s12_q.mb})
                          : ({1'b0, s12_q.ma} + {1'b0, s12_q.mb});

   lzc27 u_lzc (
      .d   (sum[26:0]),
      .cnt (lzc)
   );

   // forward S2 results into the S3 payload
   always_comb begin
      s23_d          = '0;
      s23_d.sign     = s12_q.sign;
      s23_d.exp      = s12_q.exp;
      s23_d.sum      = sum;
      s23_d.lzc      = lzc;
      s23_d.zsign    = s12_q.zsign;
      s23_d.spec     = s12_q.spec;
      s23_d.spec_val = s12_q.spec_val;
   end

   // ---------------- S3: normalize, round, pack ----------------
   logic [26:0] nm;
   logic [9:0]  e_n, e_r;
   logic        rnd;
   logic [24:0] rm;
   logic [22:0] man_r;

   // exponents carried in 10 bits so underflow shows up in bit 9
   always_comb begin
      if (s23_q.sum[27]) begin
         nm  = {s23_q.sum[27:2], s23_q.sum[1] | s23_q.sum[0]};
         e_n = {2'b00, s23_q.exp} + 10'd1;
      end else begin
         nm  = s23_q.sum[26:0] << s23_q.lzc;
         e_n = {2'b00, s23_q.exp} - {5'd0, s23_q.lzc};
      end
      rnd   = nm[2] & (nm[1] | nm[0] | nm[3]);
      rm    = {1'b0, nm[26:3]} + {24'd0, rnd};
      e_r   = rm[24] ? (e_n + 10'd1) : e_n;
      man_r = rm[24] ? rm[23:1] : rm[22:0];
      ovf_d = 1'b0;
      if (s23_q.spec)
         y_d = s23_q.spec_val;
      else if (s23_q.sum == 28'd0)
         y_d = {s23_q.zsign, 31'd0};
      else if (e_n[9] || (e_n == 10'd0))
         y_d = {s23_q.sign, 31'd0};
      else if (e_r >= 10'd255) begin
         y_d   = {s23_q.sign, FP_EXP_MAX, 23'd0};
         ovf_d = 1'b1;
      end else
         y_d = {s23_q.sign, e_r[7:0], man_r};
   end

   // stage valid bits; reset drops anything in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
      end else begin
         if (ld1) v1 <= bus.in_valid;
         if (ld2) v2 <= v1;
         if (ld3) v3 <= v2;
      end
   end

   // stage payloads and output registers; only overwritten by a real item
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s12_q <= '0;
         s23_q <= '0;
         y_q   <= 32'd0;
         ovf_q <= 1'b0;
      end else begin
         if (ld1 && bus.in_valid) s12_q <= s12_d;
         if (ld2 && v1)           s23_q <= s23_d;
         if (ld3 && v2) begin
            y_q   <= y_d;
            ovf_q <= ovf_d;
         end
      end
   end

endmodule
